// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing generator with pixel-source latency compensation.
//
// Purpose:
//   Free-running horizontal and vertical counters drive a pixel source. The
//   source returns pixel data DATA_LAT clocks after seeing a position.
//   Raw de/hsync/vsync are delayed by the same DATA_LAT clocks, so the DVI
//   outputs line up with the returned pixel data.
//
// Ports:
//   app_clk           pixel clock
//   app_rst           asynchronous active-high reset
//   vid_hpos/vid_vpos 11-bit raster counters
//   vid_active_pix    counters are inside the active area (registered)
//   vid_preload_line  one-cycle request to fetch the next active line
//   vid_data_in       {R,G,B} pixel, DATA_LAT clocks behind its position
//   dvi_hsync/vsync   active-low syncs
//   dvi_de, dvi_rgb   data enable and output pixel (blanked to 0 when de=0)
//   frame_tick        one-cycle pulse when both counters wrap to 0
//
// Build option:
//   VID_TEST_PATTERN_EN  when defined, vid_data_in is ignored and eight colour
//                        bars are output instead. Default build: pass-through.

module vid_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DATA_LAT = 2
) (
    input  logic        app_clk,
    input  logic        app_rst,
    output logic [10:0] vid_hpos,
    output logic [10:0] vid_vpos,
    output logic        vid_active_pix,
    output logic        vid_preload_line,
    input  logic [23:0] vid_data_in,
    output logic        dvi_hsync,
    output logic        dvi_vsync,
    output logic        dvi_de,
    output logic [23:0] dvi_rgb,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hpos_q, hpos_d;
    logic [10:0] vpos_q, vpos_d;
    logic [10:0] next_line;
    logic        active_q, preload_q, ftick_q;
    logic        raw_de, raw_hs, raw_vs;

    logic [DATA_LAT-1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
    logic                dvi_de_q, dvi_hs_q, dvi_vs_q;
    logic [23:0]         rgb_q;
    logic [23:0]         pix_src;

    // Counter next-state; vpos advances only on the hpos wrap.
    always_comb begin
        hpos_d = hpos_q + 11'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_LAST) ? 11'd0 : vpos_q + 11'd1;
        end
        next_line = (vpos_d == V_LAST) ? 11'd0 : vpos_d + 11'd1;
    end

    // Raw timing is decoded from the current counters.
    always_comb begin
        raw_de = (hpos_q < H_ACT) && (vpos_q < V_ACT);
        raw_hs = !((hpos_q >= HS_START) && (hpos_q < HS_END));
        raw_vs = !((vpos_q >= VS_START) && (vpos_q < VS_END));
    end

    // Status flags are computed from the next counter values so that they
    // describe the counters they appear alongside.
    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            hpos_q    <= '0;
            vpos_q    <= '0;
            active_q  <= 1'b0;
            preload_q <= 1'b0;
            ftick_q   <= 1'b0;
        end else begin
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            active_q  <= (hpos_d < H_ACT) && (vpos_d < V_ACT);
            preload_q <= (hpos_d == H_ACT) && (next_line < V_ACT);
            ftick_q   <= (hpos_d == 11'd0) && (vpos_d == 11'd0);
        end
    end

    // Delay line matching the pixel-source latency; flushes to blanking.
    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            de_pipe_q <= '0;
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
        end else begin
            de_pipe_q[0] <= raw_de;
            hs_pipe_q[0] <= raw_hs;
            vs_pipe_q[0] <= raw_vs;
            for (int i = 1; i < DATA_LAT; i++) begin
                de_pipe_q[i] <= de_pipe_q[i-1];
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
            end
        end
    end

`ifdef VID_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [2:0] bar_idx;
    logic [2:0] bar_pipe_q [DATA_LAT];
    logic [2:0] bar_out;
    logic       unused_data;

    // Bar index travels down its own delay line so colours stay aligned
    // with de exactly as external data would.
    assign bar_idx     = 3'(hpos_q / BAR_W);
    assign bar_out     = bar_pipe_q[DATA_LAT-1];
    assign unused_data = ^vid_data_in;

    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            for (int i = 0; i < DATA_LAT; i++) begin
                bar_pipe_q[i] <= '0;
            end
        end else begin
            bar_pipe_q[0] <= bar_idx;
            for (int i = 1; i < DATA_LAT; i++) begin
                bar_pipe_q[i] <= bar_pipe_q[i-1];
            end
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black:
    // R is off for idx[1], G off for idx[2], B off for idx[0].
    assign pix_src = {{8{~bar_out[1]}}, {8{~bar_out[2]}}, {8{~bar_out[0]}}};
`else
    assign pix_src = vid_data_in;
`endif

    // Output stage: all DVI signals registered on the same edge.
    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            dvi_de_q <= 1'b0;
            dvi_hs_q <= 1'b1;
            dvi_vs_q <= 1'b1;
            rgb_q    <= '0;
        end else begin
            dvi_de_q <= de_pipe_q[DATA_LAT-1];
            dvi_hs_q <= hs_pipe_q[DATA_LAT-1];
            dvi_vs_q <= vs_pipe_q[DATA_LAT-1];
            rgb_q    <= de_pipe_q[DATA_LAT-1] ? pix_src : 24'h000000;
        end
    end

    assign vid_hpos         = hpos_q;
    assign vid_vpos         = vpos_q;
    assign vid_active_pix   = active_q;
    assign vid_preload_line = preload_q;
    assign frame_tick       = ftick_q;
    assign dvi_de           = dvi_de_q;
    assign dvi_hsync        = dvi_hs_q;
    assign dvi_vsync        = dvi_vs_q;
    assign dvi_rgb          = rgb_q;

endmodule
